// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: one block-transfer request/response channel.
//   The same bundle is used for each cache-side port (cache drives the
//   request, arbiter answers) and for the shared memory side (arbiter
//   drives the request, memory answers).
//   valid/write/addr/wdata : request, held stable by the issuer until ready
//   ready                  : one-cycle completion pulse
//   rdata                  : read block, meaningful with/after ready
//   modport master : request issuer
//   modport slave  : request server
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
);
  logic              valid;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic [DATA_W-1:0] rdata;

  modport master (output valid, write, addr, wdata, input  ready, rdata);
  modport slave  (input  valid, write, addr, wdata, output ready, rdata);
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of one shared
// next-level memory, one transaction outstanding at a time.
//   clk    : clock, all state on rising edge
//   rst    : synchronous reset, active low
//   i_port : port 0 (instruction cache), slave side
//   d_port : port 1 (data cache), slave side
//   m_port : shared memory, master side
//   busy   : high whenever the arbiter is not idle
// Flow: IDLE picks a winner and latches its request, MEM presents it to
// memory until m_ready, DONE pulses the winner's ready for one cycle.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
) (
  input  logic           clk,
  input  logic           rst,
  mem_arbiter_if.slave   i_port,
  mem_arbiter_if.slave   d_port,
  mem_arbiter_if.master  m_port,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEM  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  // Port encoding for r_prio / r_grant: 0 = i_port, 1 = d_port.
  logic              r_prio;
  logic              r_grant;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_i_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic              w_req_any;
  logic              w_win;
  logic              w_grant_en;
  logic              w_capture;

  // d wins when it asks alone, or when both ask and prio points at d.
  always_comb begin
    w_req_any = i_port.valid | d_port.valid;
    w_win     = d_port.valid & (~i_port.valid | r_prio);
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_grant_en   = 1'b0;
    w_capture    = 1'b0;
    m_port.valid = 1'b0;
    i_port.ready = 1'b0;
    d_port.ready = 1'b0;
    busy         = 1'b1;
    unique case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (w_req_any) begin
          w_grant_en  = 1'b1;
          w_state_nxt = MEM;
        end
      end
      MEM: begin
        m_port.valid = 1'b1;
        if (m_port.ready) begin
          w_capture   = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        // Requests are not looked at here; requesters are still holding
        // the completed request this cycle.
        i_port.ready = ~r_grant;
        d_port.ready = r_grant;
        w_state_nxt  = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Memory sees only the latched copy, so the requesters' live inputs
  // cannot disturb an in-flight transaction.
  assign m_port.write = r_write;
  assign m_port.addr  = r_addr;
  assign m_port.wdata = r_wdata;
  assign i_port.rdata = r_i_rdata;
  assign d_port.rdata = r_d_rdata;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_prio    <= 1'b1;
      r_grant   <= 1'b0;
      r_write   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_i_rdata <= '0;
      r_d_rdata <= '0;
    end else begin
      if (w_grant_en) begin
        r_grant <= w_win;
        r_prio  <= ~w_win;
        r_write <= w_win ? d_port.write : i_port.write;
        r_addr  <= w_win ? d_port.addr  : i_port.addr;
        r_wdata <= w_win ? d_port.wdata : i_port.wdata;
      end
      // w_capture is only raised in MEM, so stray m_ready pulses are ignored.
      if (w_capture && !r_write) begin
        if (r_grant) r_d_rdata <= m_port.rdata;
        else         r_i_rdata <= m_port.rdata;
      end
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width of all request ports.
REQ-002 Parameter DATA_W, default 128, block width of data transfers; equals one cache block.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 i_valid  input  1  port 0 (instruction cache) request valid.
REQ-006 i_write  input  1  port 0 request type (1 = block write-back, 0 = block fill).
REQ-007 i_addr  input  ADDR_W  port 0 block address.
REQ-008 i_wdata  input  DATA_W  port 0 write block.
REQ-009 i_ready  output  1  port 0 completion pulse.
REQ-010 i_rdata  output  DATA_W  port 0 read block.
REQ-011 d_valid, d_write, d_addr, d_wdata, d_ready, d_rdata: port 1 (data cache), same directions, widths and meanings as port 0.
REQ-012 m_valid  output  1  request valid to shared next-level memory.
REQ-013 m_write, m_addr, m_wdata  output  1/ADDR_W/DATA_W  request fields to memory.
REQ-014 m_ready  input  1  memory completion, one-cycle pulse.
REQ-015 m_rdata  input  DATA_W  memory read block, valid when m_ready high.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 State machine: IDLE, MEM, DONE; only these three states reachable.
REQ-018 IDLE: no valid request -> stay IDLE; at least one valid -> latch winner's write/addr/wdata, record grant, go MEM.
REQ-019 Arbitration: one valid -> that port wins; both valid -> port named by priority register prio wins.
REQ-020 After every grant, prio SHALL point to the non-granted port (strict round-robin, no starvation).
REQ-021 MEM: m_valid = 1, m_write/m_addr/m_wdata driven from latched registers and held stable until m_ready sampled high.
REQ-022 MEM with m_ready high -> capture m_rdata into granted port's rdata register if read, go DONE; m_valid SHALL be 0 in the next cycle.
REQ-023 DONE: granted port's ready = 1 for exactly this one cycle; other port's ready = 0; go IDLE unconditionally.
REQ-024 Requesters hold valid and fields stable until ready seen, and drop valid in the cycle after ready; arbiter SHALL NOT sample requests in DONE.
REQ-025 Minimum latency: valid sampled at edge k -> m_valid from cycle k+1 -> ready in cycle m+1, where m is the cycle m_ready is sampled; fastest total 2 cycles.
REQ-026 i_rdata/d_rdata registered, updated only on completed reads of that port; write completions leave them unchanged.
REQ-027 Request changes on the losing port during MEM/DONE SHALL NOT alter m_* outputs.
REQ-028 m_ready outside MEM SHALL be ignored (no state change, no rdata update).
REQ-029 At most one memory transaction outstanding at any time.

Reset
REQ-030 rst low at a rising edge: state = IDLE, prio = port 1, m_valid = 0, i_ready = d_ready = 0, busy = 0, i_rdata = d_rdata = 0, latched m_write/m_addr/m_wdata = 0.
REQ-031 Reset asserted in MEM or DONE abandons the transaction: no ready pulse issued; a later m_ready is ignored per REQ-028.

Verification
REQ-032 Memory model with 3-cycle latency; d read 0x100 alone -> m_valid with m_addr=0x100, m_write=0; d_ready one cycle after m_ready; d_rdata = model block; i_ready stays 0.
REQ-033 i and d both valid first cycle after reset -> d served first (prio reset = port 1), then i; exactly one ready pulse each, in that order.
REQ-034 Both ports continuously re-request 4 times each -> grants alternate d,i,d,i,...; no port granted twice in a row.
REQ-035 d write 0x200 data 0xaabbccdd... -> m_write=1, m_wdata matches; d_rdata unchanged from its previous value.
REQ-036 Toggle i_addr during d's MEM phase -> m_addr stays at d's latched address until completion.
REQ-037 Assert rst during MEM, then pulse m_ready -> no ready pulse, state IDLE, m_valid 0, all outputs at reset values.
